mem_burst_bridge: RTL and testbench



---
 rtl/tcore_param.sv | 11 +
 rtl/mem_burst_bridge.sv | 122 ++++++++++++
 tb/tb_mem_burst_bridge.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcore_param.sv
// Shared parameters and state typedef for the memory burst bridge.
package tcore_param;
  localparam int BLK_SIZE = 128;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA,
    RESP
  } bridge_state_e;
endpackage

// File: rtl/mem_burst_bridge.sv
// Serialises one cache-block request into single-beat bus transactions.
// Optional MEM_BRIDGE_SKIP_EMPTY_EN: zero-strobe write beats are not issued.
module mem_burst_bridge #(
  parameter int BLK_SIZE = tcore_param::BLK_SIZE,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [BLK_SIZE/8-1:0] req_wstrb_i,
  input  logic [BLK_SIZE-1:0]   req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [BLK_SIZE-1:0]   rsp_rdata_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ready_i,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic                  bus_we_o,
  output logic [WORD_W/8-1:0]   bus_wstrb_o,
  output logic [WORD_W-1:0]     bus_wdata_o,
  input  logic                  bus_rvalid_i,
  input  logic [WORD_W-1:0]     bus_rdata_i
);
  import tcore_param::*;

  localparam int NBEATS = BLK_SIZE / WORD_W;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SB     = WORD_W / 8;
  localparam int BB     = BLK_SIZE / 8;
  localparam int WOFF   = $clog2(SB);
  localparam logic [BW-1:0]     LAST     = BW'(NBEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BB - 1);

  bridge_state_e       state_q;
  logic [BW-1:0]       beat_q;
  logic [ADDR_W-1:0]   base_q;
  logic [BB-1:0]       wstrb_q;
  logic [BLK_SIZE-1:0] wdata_q;
  logic [BLK_SIZE-1:0] rdata_q;
  logic                we_q;
  logic                ready_q;

  logic [SB-1:0]       strb_cur;
  logic                last;
  logic                issue;

  assign strb_cur = wstrb_q[int'(beat_q)*SB +: SB];
  assign last     = (beat_q == LAST);

`ifdef MEM_BRIDGE_SKIP_EMPTY_EN
  assign issue = (state_q == CMD) && !(we_q && (strb_cur == '0));
`else
  assign issue = (state_q == CMD);
`endif

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign bus_valid_o = issue;
  assign bus_addr_o  = base_q + (ADDR_W'(beat_q) << WOFF);
  assign bus_we_o    = we_q;
  assign bus_wstrb_o = strb_cur;
  assign bus_wdata_o = wdata_q[int'(beat_q)*WORD_W +: WORD_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && req_valid_i) begin
            ready_q <= 1'b0;
            base_q  <= req_addr_i & ~OFF_MASK;
            wstrb_q <= req_wstrb_i;
            wdata_q <= req_wdata_i;
            we_q    <= |req_wstrb_i;
            beat_q  <= '0;
            state_q <= CMD;
          end
        end
        CMD: begin
          // a suppressed beat advances without waiting for the bus
          if (!issue || bus_ready_i) begin
            if (!we_q) begin
              state_q <= RDATA;
            end else if (last) begin
              state_q <= RESP;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        RDATA: begin
          if (bus_rvalid_i) begin
            rdata_q[int'(beat_q)*WORD_W +: WORD_W] <= bus_rdata_i;
            if (last) begin
              state_q <= RESP;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= CMD;
            end
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_bridge.sv
// Randomised bench for mem_burst_bridge with a block-level reference model.
`timescale 1ns/1ps
module tb_mem_burst_bridge;
  localparam int BLK = 128;
  localparam int WW  = 32;
  localparam int AW  = 32;
  localparam int NB  = BLK / WW;
  localparam int SB  = WW / 8;
  localparam int BB  = BLK / 8;
`ifdef MEM_BRIDGE_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [AW-1:0]  req_addr = '0;
  logic [BB-1:0]  req_wstrb = '0;
  logic [BLK-1:0] req_wdata = '0;
  logic           rsp_valid;
  logic [BLK-1:0] rsp_rdata;
  logic           bus_valid;
  logic           bus_ready = 1'b0;
  logic [AW-1:0]  bus_addr;
  logic           bus_we;
  logic [SB-1:0]  bus_wstrb;
  logic [WW-1:0]  bus_wdata;
  logic           bus_rvalid = 1'b0;
  logic [WW-1:0]  bus_rdata = '0;

  mem_burst_bridge #(
    .BLK_SIZE(BLK),
    .WORD_W  (WW),
    .ADDR_W  (AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wstrb_i (req_wstrb),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .bus_valid_o (bus_valid),
    .bus_ready_i (bus_ready),
    .bus_addr_o  (bus_addr),
    .bus_we_o    (bus_we),
    .bus_wstrb_o (bus_wstrb),
    .bus_wdata_o (bus_wdata),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          we;
    logic [SB-1:0] s;
    logic [WW-1:0] d;
  } beat_t;

  beat_t          exp_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc = 0;
  int             t_iss = 0;
  int             n_beats = 0;
  int             n_acc = 0;
  int             rdy_lo = 0, rdy_hi = 0;
  int             rv_lo = 0, rv_hi = 0;
  int             stall = -1;
  int             rv_cnt = 0;
  bit             busy = 0, pend_iss = 0, rdy_next = 0;
  bit             zw = 0, tbl_mode = 0, pend_rd = 0;
  bit             rst_arm = 0, exp_we = 0;
  logic [AW-1:0]  rd_addr = '0;
  logic [AW-1:0]  iss_addr = '0;
  logic [BB-1:0]  iss_strb = '0;
  logic [BLK-1:0] iss_wdata = '0;
  logic [BLK-1:0] exp_blk = '0;
  logic [BLK-1:0] last_blk = '0;
  logic [WW-1:0]  tbl [4] = '{32'h11111111, 32'h22222222,
                              32'h33333333, 32'h44444444};

  task automatic chk(string tag, logic [BLK-1:0] got,
                     logic [BLK-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] rd_word(logic [AW-1:0] a);
    if (tbl_mode) return tbl[a[3:2]];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    #1;
    chk("rst_bus_valid", BLK'(bus_valid), BLK'(0));
    chk("rst_rsp_valid", BLK'(rsp_valid), BLK'(0));
    chk("rst_req_ready", BLK'(req_ready), BLK'(0));
    chk("rst_rdata", rsp_rdata, BLK'(0));
    exp_q.delete();
    busy = 0;
    pend_rd = 0;
    rst_arm = 0;
    rdy_next = 0;
    stall = -1;
    last_blk = '0;
  endtask

  task automatic step();
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    logic [SB-1:0] s;
    @(posedge clk);
    #1;
    cyc++;
    req_valid = 1'b0;

    if (rsp_valid) begin
      if (!busy) begin
        chk("spurious_rsp", BLK'(1), BLK'(0));
      end else begin
        chk("rsp_data", rsp_rdata, exp_blk);
        chk("beats_left", BLK'(exp_q.size()), BLK'(0));
        if (zw)
          chk("latency", BLK'(cyc - t_iss),
              BLK'(exp_we ? NB + 1 : 2 * NB + 1));
        busy = 0;
        last_blk = exp_blk;
        rdy_next = 1;
      end
    end else if (rdy_next) begin
      chk("ready_after_rsp", BLK'(req_ready), BLK'(1));
      rdy_next = 0;
    end else if (busy) begin
      chk("ready_busy", BLK'(req_ready), BLK'(0));
    end
    if (!busy) chk("blk_hold", rsp_rdata, last_blk);

    bus_rvalid = 1'b0;
    if (pend_rd) begin
      if (rst_arm && n_acc == 3) begin
        do_reset();
        return;
      end
      if (rv_cnt == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata = rd_word(rd_addr);
        pend_rd = 0;
      end else begin
        rv_cnt--;
      end
    end else if ($urandom_range(3) == 0) begin
      bus_rvalid = 1'b1;
      bus_rdata = $urandom;
    end

    if (bus_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", BLK'(1), BLK'(0));
      end else begin
        chk("bus_addr", BLK'(bus_addr), BLK'(exp_q[0].a));
        chk("bus_we", BLK'(bus_we), BLK'(exp_q[0].we));
        chk("bus_wstrb", BLK'(bus_wstrb), BLK'(exp_q[0].s));
        if (exp_q[0].we)
          chk("bus_wdata", BLK'(bus_wdata), BLK'(exp_q[0].d));
      end
      if (stall < 0) stall = $urandom_range(rdy_hi, rdy_lo);
      if (stall == 0) begin
        bus_ready = 1'b1;
        stall = -1;
        n_beats++;
        if (!bus_we) begin
          pend_rd = 1;
          rv_cnt = $urandom_range(rv_hi, rv_lo);
          rd_addr = bus_addr;
          n_acc++;
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        bus_ready = 1'b0;
        stall--;
      end
    end else begin
      bus_ready = 1'($urandom);
    end

    if (pend_iss && req_ready && !busy && rst_n) begin
      req_valid = 1'b1;
      req_addr = iss_addr;
      req_wstrb = iss_strb;
      req_wdata = iss_wdata;
      busy = 1;
      pend_iss = 0;
      t_iss = cyc;
      n_acc = 0;
      exp_we = |iss_strb;
      base = iss_addr & ~AW'(BB - 1);
      exp_blk = last_blk;
      for (int k = 0; k < NB; k++) begin
        a = base + AW'(SB * k);
        if (exp_we) begin
          s = iss_strb[k*SB +: SB];
          if (s != '0 || !SKIP)
            exp_q.push_back(beat_t'{a, 1'b1, s, iss_wdata[k*WW +: WW]});
        end else begin
          exp_q.push_back(beat_t'{a, 1'b0, '0, '0});
          exp_blk[k*WW +: WW] = rd_word(a);
        end
      end
    end
  endtask

  task automatic run_req(logic [AW-1:0] a, logic [BB-1:0] st,
                         logic [BLK-1:0] wd);
    iss_addr = a;
    iss_strb = st;
    iss_wdata = wd;
    pend_iss = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!pend_iss && !busy) return;
    end
    chk("timeout", BLK'(1), BLK'(0));
    pend_iss = 0;
    busy = 0;
  endtask

  task automatic set_bus(int rl, int rh, int vl, int vh, bit z);
    rdy_lo = rl;
    rdy_hi = rh;
    rv_lo = vl;
    rv_hi = vh;
    zw = z;
  endtask

  initial begin
    int nb0;
    logic [BB-1:0] st;
    #2;
    chk("reset_ready", BLK'(req_ready), BLK'(0));
    chk("reset_rsp_valid", BLK'(rsp_valid), BLK'(0));
    chk("reset_rdata", rsp_rdata, BLK'(0));
    chk("reset_bus_valid", BLK'(bus_valid), BLK'(0));
    chk("reset_bus_outs",
        BLK'({bus_we, bus_addr, bus_wstrb, bus_wdata}), BLK'(0));
    repeat (2) step();
    rst_n = 1'b1;

    set_bus(0, 0, 0, 0, 1);
    tbl_mode = 1;
    run_req(32'h0000_1034, '0, {4{$urandom}});
    chk("tp_read_blk", rsp_rdata,
        128'h44444444_33333333_22222222_11111111);
    tbl_mode = 0;

    run_req(32'h0000_2000, '1,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    chk("tp_write_hold", rsp_rdata,
        128'h44444444_33333333_22222222_11111111);

    nb0 = n_beats;
    run_req(32'h0000_2000, 16'h0F00, {4{$urandom}});
    chk("tp_sparse_beats", BLK'(n_beats - nb0), BLK'(SKIP ? 1 : 4));

    set_bus(3, 3, 2, 2, 0);
    run_req(32'h0000_4A10, '0, '0);

    set_bus(0, 1, 3, 3, 0);
    rst_arm = 1;
    run_req(32'h0000_5000, '0, '0);
    chk("rst_taken", BLK'(rst_arm), BLK'(0));
    repeat (3) begin
      step();
      chk("rst_hold_valid", BLK'(bus_valid), BLK'(0));
    end
    rst_n = 1'b1;
    set_bus(0, 0, 0, 0, 1);
    run_req(32'h0000_6008, '0, '0);

    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) set_bus(0, 0, 0, 0, 1);
      else set_bus(0, $urandom_range(2), 0, $urandom_range(2), 0);
      st = '0;
      if ($urandom_range(1) == 1) begin
        for (int k = 0; k < NB; k++) begin
          case ($urandom_range(2))
            0: st[k*SB +: SB] = '0;
            1: st[k*SB +: SB] = '1;
            default: st[k*SB +: SB] = SB'($urandom);
          endcase
        end
        if (st == '0) st[0] = 1'b1;
      end
      run_req($urandom, st, {$urandom, $urandom, $urandom, $urandom});
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
